// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared sizes, FSM states and operand index helpers for the window scheduler
package conv_pkg;
   localparam int DW     = 8;
   localparam int N      = 4;
   localparam int K      = 3;
   localparam int OW     = N - K + 1;
   localparam int NWIN   = OW * OW;
   localparam int NTAP   = K * K;
   localparam int WIN_W  = $clog2(NWIN);
   localparam int TAP_W  = $clog2(NTAP);
   localparam int AIDX_W = $clog2(N * N);
   localparam int BIDX_W = $clog2(NTAP);

   typedef enum logic [2:0] {IDLE, LOAD, SETTLE, FEED, DONE} state_t;

   // Word index into the row-major A matrix for a given window and filter tap.
   function automatic logic [AIDX_W-1:0] a_index(input logic [WIN_W-1:0] win,
                                                  input logic [TAP_W-1:0] tap);
      int w;
      int t;
      w = int'(win);
      t = int'(tap);
      return AIDX_W'(((w / OW) + (t / K)) * N + (w % OW) + (t % K));
   endfunction

   function automatic logic [BIDX_W-1:0] b_index(input logic [TAP_W-1:0] tap);
      int t;
      t = int'(tap);
      return BIDX_W'((t / K) * K + (t % K));
   endfunction
endpackage

// File: rtl/conv_tap_counter.sv
// rtl/conv_tap_counter.sv - window/tap position counters with first, last and final-pair flags
module conv_tap_counter
   import conv_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             advance,
   input  logic             clear,
   output logic [WIN_W-1:0] win,
   output logic [TAP_W-1:0] tap,
   output logic             first,
   output logic             last,
   output logic             is_final
);
   assign first    = (tap == '0);
   assign last     = (tap == TAP_W'(NTAP - 1));
   assign is_final = last && (win == WIN_W'(NWIN - 1));

   // The final transfer returns both counters to zero so they never wrap mid-pass.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win <= '0;
         tap <= '0;
      end else if (clear || (advance && is_final)) begin
         win <= '0;
         tap <= '0;
      end else if (advance) begin
         if (last) begin
            tap <= '0;
            win <= win + WIN_W'(1);
         end else begin
            tap <= tap + TAP_W'(1);
         end
      end
   end
endmodule

// File: rtl/conv_window_scheduler.sv
// rtl/conv_window_scheduler.sv - sequences operand memory capture and streams (A, B) pairs per 3x3 window
module conv_window_scheduler
   import conv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [N*N*DW-1:0]     mat_a,
   input  logic [K*K*DW-1:0]     filt_b,
   output logic                  mem_load,
   output logic                  feed_valid,
   input  logic                  feed_ready,
   output logic [DW-1:0]         feed_a,
   output logic [DW-1:0]         feed_b,
   output logic [WIN_W-1:0]      feed_win,
   output logic                  feed_first,
   output logic                  feed_last,
   output logic                  busy,
   output logic                  done
);
   state_t           state;
   logic [WIN_W-1:0] win;
   logic [TAP_W-1:0] tap;
   logic             first;
   logic             last;
   logic             is_final;
   logic             xfer;
   logic [DW-1:0]    a_words [N*N];
   logic [DW-1:0]    b_words [NTAP];

   assign xfer = feed_valid && feed_ready;

   conv_tap_counter u_cnt (
      .clk      (clk),
      .rst      (rst),
      .advance  (xfer),
      .clear    (state == LOAD),
      .win      (win),
      .tap      (tap),
      .first    (first),
      .last     (last),
      .is_final (is_final)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         mem_load   <= 1'b0;
         feed_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state    <= LOAD;
               mem_load <= 1'b1;
               busy     <= 1'b1;
            end
            LOAD: begin
               state    <= SETTLE;
               mem_load <= 1'b0;
            end
            SETTLE: begin
               state      <= FEED;
               feed_valid <= 1'b1;
            end
            FEED: if (xfer && is_final) begin
               state      <= DONE;
               feed_valid <= 1'b0;
               done       <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               mem_load   <= 1'b0;
               feed_valid <= 1'b0;
               busy       <= 1'b0;
               done       <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < N * N; i++) begin : g_a_words
      assign a_words[i] = mat_a[i*DW +: DW];
   end
   for (genvar i = 0; i < NTAP; i++) begin : g_b_words
      assign b_words[i] = filt_b[i*DW +: DW];
   end

   // feed_valid is registered and only high in FEED, so it doubles as the output gate.
   assign feed_a     = feed_valid ? a_words[a_index(win, tap)] : '0;
   assign feed_b     = feed_valid ? b_words[b_index(tap)]      : '0;
   assign feed_win   = feed_valid ? win   : '0;
   assign feed_first = feed_valid ? first : 1'b0;
   assign feed_last  = feed_valid ? last  : 1'b0;
endmodule

// File: doc/conv_window_scheduler.md
Name: conv_window_scheduler

Overview:
- Controller that sequences the operand memory (4x4 matrix A, 3x3 filter B, each word held in an 8-bit register) into the systolic array.
- Pulses the memory capture enable, waits one cycle for the register outputs to settle, then streams (A, B) operand pairs for every 3x3 convolution window over a valid/ready handshake.
- Output order: window-major, then tap-major.
- Sits between the top-level start/done control, the operand memory and the array's operand input port.

Parameters:
- DW, 8, operand width in bits
- N, 4, input matrix dimension (N x N)
- K, 3, filter dimension (K x K)
- Derived, not overridable: OW = N-K+1 output windows per row/column (2); NWIN = OW*OW (4); NTAP = K*K (9)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request one full convolution pass; sampled only in IDLE
- mat_a  in  N*N*DW (128)  registered memory outputs, row-major; A11 at [7:0], A12 at [15:8], ..., A44 at [127:120]
- filt_b  in  K*K*DW (72)  registered filter outputs, row-major; B11 at [7:0], ..., B33 at [71:64]
- mem_load  out  1  one-cycle capture enable to the operand memory
- feed_valid  out  1  operand pair valid
- feed_ready  in  1  array accepts the pair this cycle
- feed_a  out  DW  matrix operand
- feed_b  out  DW  filter operand
- feed_win  out  2  window index, win = wr*OW + wc
- feed_first  out  1  first tap of a window (tap 0)
- feed_last  out  1  last tap of a window (tap NTAP-1)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final transfer

Behaviour:
- Reset (rst low, asynchronous): state IDLE; win and tap counters cleared to 0; every output 0.
- A reset asserted mid-pass aborts the pass with no done pulse. After rst releases, the block waits for a fresh start.

State machine, states IDLE, LOAD, SETTLE, FEED, DONE:
- IDLE: when start is high at an edge, go to LOAD.
- LOAD: mem_load = 1 for exactly this one cycle; go to SETTLE.
- SETTLE: one idle cycle while the memory registers update; go to FEED.
- FEED: feed_valid = 1. A transfer is valid && ready in the same cycle.
  - On a transfer: if tap < NTAP-1, increment tap; else clear tap to 0 and increment win.
  - A transfer with win = NWIN-1 and tap = NTAP-1 goes to DONE.
- DONE: done = 1 for one cycle; go to IDLE.
- start is ignored in every state except IDLE. start held high continuously re-launches a pass from IDLE.

Operand selection:
- wr = win / OW, wc = win % OW; kr = tap / K, kc = tap % K.
- feed_a = mat_a word at index (wr+kr)*N + (wc+kc).
- feed_b = filt_b word at index kr*K + kc.
- feed_a, feed_b, feed_win, feed_first and feed_last are decoded from the registered counters.
- They are held stable while feed_valid && !feed_ready. No pair is ever skipped or duplicated.
- Outside FEED, these outputs are driven to 0.

Latency and handshake:
- start sampled at edge t: mem_load high in cycle t+1, SETTLE in t+2, first valid in t+3.
- With feed_ready held high: NWIN*NTAP = 36 transfers in cycles t+3..t+38, done in t+39, busy low from t+40.
- Each cycle of deasserted feed_ready adds exactly one cycle.
- Index arithmetic is unsigned; widths are computed with clog2. The win and tap counters never wrap inside a pass.

Decomposition:
- Shared package conv_pkg holds:
  - DW, N, K, OW, NWIN, NTAP
  - state enum (IDLE, LOAD, SETTLE, FEED, DONE)
  - functions a_index(win, tap) and b_index(tap)
- One natural sub-module, conv_tap_counter: win/tap counters with advance and clear inputs, plus first/last/final flags. The top-level module holds the FSM and the operand muxes.

Test Plan:
- Basic pass: A = 1..16 row-major, B = 1..9, feed_ready always high, start pulsed at t.
  - mem_load at t+1; first pair (a=1, b=1, win=0, first=1) at t+3.
  - Window 0 feed_a sequence: 1,2,3,5,6,7,9,10,11.
  - Last pair (a=16, b=9, win=3, last=1) at t+38; done at t+39.
- Window ordering: same data, B all 1; the bench sums feed_a per window.
  - Sums: win0 = 54, win1 = 63, win2 = 90, win3 = 99.
  - First a per window: 1, 2, 5, 6.
- Backpressure: feed_ready low for 3 cycles at tap 4 of win 1.
  - feed_a = 7, feed_b = 5, feed_win = 1 held constant over those cycles.
  - No skip or repeat; done arrives 3 cycles later than in the basic pass.
- Start while busy: pulse start during FEED.
  - Ignored: exactly 36 transfers, one done, one mem_load.
- Mid-pass reset: drive rst low at transfer 20.
  - All outputs are 0 immediately (asynchronous); no done pulse.
  - After rst releases and start is pulsed, the pass restarts at win=0, tap=0.
- Back-to-back passes: start held high.
  - The second mem_load follows one cycle after done; busy is low for exactly one cycle between passes.
